// File: rtl/uart_ctrl.sv
// Register-mapped UART controller: byte-wide bus front end with TX/RX FIFOs,
// a transmit handshake FSM and a receive capture FSM.
module uart_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_clear,
  output logic       rx_avail
);

  localparam int DATA_W = 8;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } txState_t;

  typedef enum logic {
    RX_IDLE,
    RX_CLR
  } rxState_t;

  txState_t txState, txNext;
  rxState_t rxState, rxNext;

  logic dataWr, dataRd, statWr, statRd;

  logic [DATA_W-1:0] txMem [FIFO_DEPTH];
  logic [AW-1:0]     txWrPtr, txRdPtr;
  logic [CW-1:0]     txCount;
  logic              txFull, txEmpty, txPop, txPushOk, txOvfSet;

  logic [DATA_W-1:0] rxMem [FIFO_DEPTH];
  logic [AW-1:0]     rxWrPtr, rxRdPtr;
  logic [CW-1:0]     rxCount;
  logic              rxFull, rxEmpty, rxPush, rxPop, rxPushOk, rxOvfSet;

  logic              txOvf, rxOvf, txIdle;
  logic [DATA_W-1:0] statusWord;
  logic [DATA_W-1:0] readWord;

  assign dataWr = req &  we & ~addr;
  assign dataRd = req & ~we & ~addr;
  assign statWr = req &  we &  addr;
  assign statRd = req & ~we &  addr;

  assign txFull  = (txCount == DEPTH_C);
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == DEPTH_C);
  assign rxEmpty = (rxCount == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign txPushOk = dataWr & (~txFull | txPop);
  assign txOvfSet = dataWr & txFull & ~txPop;
  assign rxPop    = dataRd & ~rxEmpty;
  assign rxPushOk = rxPush & (~rxFull | rxPop);
  assign rxOvfSet = rxPush & rxFull & ~rxPop;

  assign txIdle     = txEmpty & (txState == IDLE) & ~tx_busy;
  assign statusWord = {3'b000, txOvf, rxOvf, txIdle, ~rxEmpty, ~txFull};
  assign readWord   = statRd ? statusWord : (rxEmpty ? '0 : rxMem[rxRdPtr]);

  assign rx_avail = ~rxEmpty;
  assign rx_clear = (rxState == RX_CLR);

  // TX FSM next state and pop decision
  always_comb begin
    txNext = txState;
    txPop  = 1'b0;
    case (txState)
      IDLE: begin
        if (!txEmpty && !tx_busy) begin
          txPop  = 1'b1;
          txNext = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy)  txNext = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) txNext = IDLE;
      default:   txNext = IDLE;
    endcase
  end

  // RX FSM: one push per ready assertion, then a single clear cycle
  always_comb begin
    rxNext = rxState;
    rxPush = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (rx_ready) begin
          rxPush = 1'b1;
          rxNext = RX_CLR;
        end
      end
      RX_CLR:  rxNext = RX_IDLE;
      default: rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txState <= IDLE;
      rxState <= RX_IDLE;
    end else begin
      txState <= txNext;
      rxState <= rxNext;
    end
  end

  // TX FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPushOk) txWrPtr <= txWrPtr + AW'(1);
      if (txPop)    txRdPtr <= txRdPtr + AW'(1);
      case ({txPushOk, txPop})
        2'b10:   txCount <= txCount + CW'(1);
        2'b01:   txCount <= txCount - CW'(1);
        default: txCount <= txCount;
      endcase
    end
  end

  // RX FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPushOk) rxWrPtr <= rxWrPtr + AW'(1);
      if (rxPop)    rxRdPtr <= rxRdPtr + AW'(1);
      case ({rxPushOk, rxPop})
        2'b10:   rxCount <= rxCount + CW'(1);
        2'b01:   rxCount <= rxCount - CW'(1);
        default: rxCount <= rxCount;
      endcase
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the counts above
  always_ff @(posedge clk) begin
    if (!rst && txPushOk) txMem[txWrPtr] <= wdata;
    if (!rst && rxPushOk) rxMem[rxWrPtr] <= rx_data;
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      txOvf <= 1'b0;
      rxOvf <= 1'b0;
    end else begin
      txOvf <= txOvfSet | (txOvf & ~(statWr & wdata[4]));
      rxOvf <= rxOvfSet | (rxOvf & ~(statWr & wdata[3]));
    end
  end

  // Bus response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= (req && !we) ? readWord : '0;
    end
  end

  // Transmitter launch stage; tx_data holds until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= txPop;
      if (txPop) tx_data <= txMem[txRdPtr];
    end
  end

endmodule
